accum_bcd_converter: RTL and testbench
======================================

Name: accum_bcd_converter

Overview:
- Downstream consumer of the calculator's 32-bit accumulator register output.
- Converts the signed two's-complement accumulator value into a sign flag plus packed BCD digits for the display/readout stage.
- Uses a sequential double-dabble (shift-and-add-3) engine, one bit per clock, with a start/busy/done handshake.
- Results are held stable between conversions so the display logic can sample them at any time.

Parameters:
- WIDTH, 32, bit width of the input value (matches the accumulator width).
- DIGITS, 10, number of BCD digits produced. Must be >= ceil(WIDTH*log10(2)); 10 covers 2^31 = 2147483648.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a conversion of value; sampled only when busy=0
- value  input  WIDTH  signed two's-complement operand (accumulator output)
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when bcd/negative update with a new result
- negative  output  1  sign of the last converted value (1 = negative)
- bcd  output  4*DIGITS  packed BCD magnitude of the last converted value; digit 0 is in bits [3:0]

Behaviour:
- Reset (synchronous, active-high, priority over all other inputs):
  - State goes to IDLE.
  - busy=0, done=0, negative=0, bcd=0.
  - Internal shift register and counter are cleared.
  - An in-flight conversion is aborted and produces no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. If start=1 at an edge:
  - capture sign = value[WIDTH-1];
  - capture magnitude = sign ? (~value + 1) : value, as WIDTH-bit unsigned, so -2^(WIDTH-1) gives magnitude 2^(WIDTH-1);
  - clear the BCD scratch and set counter=0;
  - go to SHIFT.
- SHIFT: busy=1. Each edge performs one iteration:
  - every scratch digit >= 5 gets +3 (all digits evaluated in parallel from pre-adjust values);
  - then {scratch, magnitude} shifts left by 1, and the magnitude MSB enters scratch bit 0;
  - counter increments.
  - After the WIDTH-th iteration (counter reaches WIDTH-1 at that edge), go to DONE.
  - The bcd and negative outputs do not change during SHIFT.
- DONE (single cycle), entered on the same edge that finishes the last iteration:
  - bcd <= final scratch and negative <= captured sign, both registered on that edge;
  - done=1 and busy=0 during the DONE cycle;
  - if start=1 during DONE, a new conversion is accepted exactly as from IDLE (back-to-back); otherwise go to IDLE.
- Latency:
  - start sampled at edge E0;
  - busy high for cycles following E0 through E0+WIDTH-1;
  - done high in the cycle following edge E0+WIDTH, i.e. WIDTH+1 cycles after the start edge (33 for the default).
- Other boundary rules:
  - start while busy=1 is ignored; value changes during SHIFT have no effect because the operand is captured at start.
  - Zero converts to negative=0 and bcd=0. There is no negative zero.
  - bcd and negative hold their last result indefinitely until the next done or a reset.
  - No digit can exceed 9 for legal DIGITS; the output has no overflow path.
  - done is never high for two consecutive cycles unless back-to-back starts were accepted; even then each done is separated by WIDTH cycles.

Test Plan:
- Reset, then start with value=0 -> busy high for 32 cycles; done pulse at cycle 33 after the start edge; bcd=0x0000000000, negative=0.
- value=12345 (0x00003039) -> bcd=0x0000012345, negative=0; value=0x7FFFFFFF -> bcd=0x2147483647, negative=0.
- value=0xFFFFFFFF (-1) -> bcd=0x0000000001, negative=1; value=0x80000000 -> bcd=0x2147483648, negative=1.
- Start with 100, pulse start again with 999 at cycle 10 and change value mid-run -> second start ignored; result bcd=0x0000000100; exactly one done pulse.
- Start with -42, assert reset at cycle 15 -> next cycle busy=0, done=0, bcd=0, negative=0; no done pulse follows.
- Hold start=1 continuously with value=7, then switch to value=-8 right after the first done -> done pulses 33 cycles apart; first bcd=0x7/negative=0, second bcd=0x8/negative=1; outputs stable between pulses.

Source files
------------

// File: rtl/accum_bcd_converter.sv
// Signed accumulator to sign + packed BCD converter.
// Sequential double-dabble engine, one magnitude bit per clock.
module accum_bcd_converter #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic                  negative,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [BW-1:0]   r_scratch;
    logic [WIDTH-1:0] r_mag;
    logic            r_sign;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_neg;
    logic [BW-1:0]   r_bcd;

    logic [BW-1:0]    w_adj;
    logic [BW-1:0]    w_scratch_nxt;
    logic [WIDTH-1:0] w_mag_abs;

    // Add-3 on every digit from pre-adjust values, then shift in the next bit.
    always_comb begin
        w_adj = r_scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
        end
        w_scratch_nxt = {w_adj[BW-2:0], r_mag[WIDTH-1]};
        w_mag_abs = value[WIDTH-1] ? (~value) + WIDTH'(1) : value;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_scratch <= '0;
            r_mag     <= '0;
            r_sign    <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_neg     <= 1'b0;
            r_bcd     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_sign    <= value[WIDTH-1];
                        r_mag     <= w_mag_abs;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= w_scratch_nxt;
                    r_mag     <= r_mag << 1;
                    r_cnt     <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_bcd   <= w_scratch_nxt;
                        r_neg   <= r_sign;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign negative = r_neg;
    assign bcd      = r_bcd;

endmodule

// File: tb/tb_accum_bcd_converter.sv
// Self-checking bench for accum_bcd_converter.
// Arithmetic reference model plus directed vectors with literal results.
module tb_accum_bcd_converter;

    localparam int W = 32;
    localparam int D = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [W-1:0]    value = '0;
    logic            busy;
    logic            done;
    logic            negative;
    logic [4*D-1:0]  bcd;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    accum_bcd_converter #(.WIDTH(W), .DIGITS(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .negative (negative),
        .bcd      (bcd)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Decimal digits of |v| by repeated division.
    function automatic logic [4*D-1:0] to_bcd(input logic [W-1:0] v);
        longint m;
        logic [4*D-1:0] r;
        m = longint'($signed(v));
        if (m < 0) m = -m;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference timing: accepted start -> WIDTH busy cycles -> one done cycle.
    int              m_left = 0;
    logic            m_busy = 1'b0;
    logic            m_done = 1'b0;
    logic            m_neg  = 1'b0;
    logic [4*D-1:0]  m_bcd  = '0;
    logic [W-1:0]    p_val  = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_left <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_bcd  <= '0;
            m_neg  <= 1'b0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_bcd  <= to_bcd(p_val);
                m_neg  <= p_val[W-1];
            end
            m_left <= m_left - 1;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_busy <= 1'b1;
                m_left <= W;
                p_val  <= value;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("neg",  64'(negative), 64'(m_neg));
            chk("bcd",  64'(bcd), 64'(m_bcd));
        end
    end

    task automatic convert(input logic [W-1:0] v,
                           input logic [4*D-1:0] eb, input logic en);
        int n;
        int nb;
        @(negedge clk);
        start = 1'b1;
        value = v;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        nb = busy ? 1 : 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
        end
        chk("latency", 64'(n), 64'(33));
        chk("busy_cycles", 64'(nb), 64'(32));
        chk("lit_bcd", 64'(bcd), 64'(eb));
        chk("lit_neg", 64'(negative), 64'(en));
    endtask

    initial begin
        int dcnt;
        int n;

        chk("model_12345", 64'(to_bcd(32'd12345)), 64'(40'h0000012345));
        chk("model_min", 64'(to_bcd(32'h80000000)), 64'(40'h2147483648));
        chk("model_m1", 64'(to_bcd(32'hFFFFFFFF)), 64'(40'h0000000001));

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_bcd", 64'(bcd), 64'(0));
        chk("rst_neg", 64'(negative), 64'(0));
        chk_en = 1'b1;
        reset = 1'b0;

        convert(32'd0,        40'h0000000000, 1'b0);
        convert(32'h00003039, 40'h0000012345, 1'b0);
        convert(32'h7FFFFFFF, 40'h2147483647, 1'b0);
        convert(32'hFFFFFFFF, 40'h0000000001, 1'b1);
        convert(32'h80000000, 40'h2147483648, 1'b1);

        // Start while busy and mid-run value changes must be ignored.
        @(negedge clk);
        start = 1'b1;
        value = 32'd100;
        dcnt = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 10) begin
                start = 1'b1;
                value = 32'd999;
            end
            if (k == 11) start = 1'b0;
            if (k == 20) value = 32'h12345678;
            if (done) begin
                dcnt++;
                chk("ign_latency", 64'(k), 64'(33));
            end
        end
        chk("ign_dones", 64'(dcnt), 64'(1));
        chk("ign_bcd", 64'(bcd), 64'(40'h0000000100));
        chk("ign_neg", 64'(negative), 64'(0));

        // Reset aborts a conversion in flight.
        @(negedge clk);
        start = 1'b1;
        value = 32'hFFFFFFD6;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_bcd", 64'(bcd), 64'(0));
        chk("abort_neg", 64'(negative), 64'(0));
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_nodone", 64'(dcnt), 64'(0));

        // Back-to-back conversions with start held high.
        @(negedge clk);
        start = 1'b1;
        value = 32'd7;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        chk("b2b1_latency", 64'(n), 64'(33));
        chk("b2b1_bcd", 64'(bcd), 64'(40'h0000000007));
        chk("b2b1_neg", 64'(negative), 64'(0));
        value = 32'hFFFFFFF8;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        start = 1'b0;
        chk("b2b2_gap", 64'(n), 64'(33));
        chk("b2b2_bcd", 64'(bcd), 64'(40'h0000000008));
        chk("b2b2_neg", 64'(negative), 64'(1));

        repeat (5) @(negedge clk);
        chk("hold_bcd", 64'(bcd), 64'(40'h0000000008));
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
